// File: rtl/m68k_bus_target.sv
// m68k_bus_target: bridges asynchronous 68000 bus cycles to a local req/ack port; define M68K_TARGET_BERR_TIMEOUT_EN to add a BERR timeout
module m68k_bus_target #(
   parameter logic [23:0] BASE_ADDR      = 24'hE90000,
   parameter logic [23:0] ADDR_MASK      = 24'hFF0000,
   parameter logic [7:0]  TIMEOUT_CYCLES = 8'd64
) (
   input  logic        PI_CLK,
   input  logic        SYS_RESET,
   input  logic        M68K_CLK,
   input  logic        M68K_AS_n,
   input  logic        M68K_UDS_n,
   input  logic        M68K_LDS_n,
   input  logic        M68K_RW,
   input  logic [2:0]  M68K_FC,
   input  logic [22:0] M68K_A,
   input  logic [15:0] M68K_D_IN,
   output logic [15:0] M68K_D_OUT,
   output logic        M68K_D_OE,
   output logic        M68K_DTACK_n,
   output logic        M68K_BERR_n,
   output logic        LOC_REQ,
   output logic        LOC_RW,
   output logic [22:0] LOC_ADDR,
   output logic [1:0]  LOC_BE,
   output logic [15:0] LOC_WDATA,
   input  logic        LOC_ACK,
   input  logic        LOC_ERR,
   input  logic [15:0] LOC_RDATA
);
   typedef enum logic [2:0] {IDLE, DECODE, LOCAL, RESPOND, RELEASE} state_t;
   state_t     r_state, w_next;
   logic [2:0] r_clk_s, r_as_s, r_uds_s, r_lds_s;
   logic [1:0] r_fill;
   logic       r_armed, r_err;
   logic       w_rise, w_fall, w_as, w_uds, w_lds, w_start, w_match, w_timeout, w_unused;

   assign w_rise   = r_clk_s[1] & ~r_clk_s[2];
   assign w_fall   = ~r_clk_s[1] & r_clk_s[2];
   assign w_as     = r_as_s[2];
   assign w_uds    = r_uds_s[2];
   assign w_lds    = r_lds_s[2];
   assign w_start  = r_armed & ~w_as & ~(w_uds & w_lds);
   assign w_match  = ((({M68K_A, 1'b0} ^ BASE_ADDR) & ADDR_MASK) == 24'd0) && (M68K_FC != 3'b111);
   assign w_unused = ^{w_rise, TIMEOUT_CYCLES};

`ifdef M68K_TARGET_BERR_TIMEOUT_EN
   logic [7:0] r_tmo;
   assign w_timeout = (r_state == LOCAL) && w_fall && (r_tmo == TIMEOUT_CYCLES - 8'd1);
   // count bus-clock falling edges spent waiting for the local side; zero outside LOCAL
   always_ff @(posedge PI_CLK)
      if (SYS_RESET || r_state != LOCAL) r_tmo <= '0;
      else if (w_fall) r_tmo <= r_tmo + 8'd1;
`else
   assign w_timeout = 1'b0;
`endif

   // synchronizers; r_fill waits until reset-preset ones have flushed so a held AS_n must be seen high before arming
   always_ff @(posedge PI_CLK)
      if (SYS_RESET) begin
         r_clk_s <= '1;
         r_as_s  <= '1;
         r_uds_s <= '1;
         r_lds_s <= '1;
         r_fill  <= '0;
         r_armed <= 1'b0;
      end else begin
         r_clk_s <= {r_clk_s[1:0], M68K_CLK};
         r_as_s  <= {r_as_s[1:0], M68K_AS_n};
         r_uds_s <= {r_uds_s[1:0], M68K_UDS_n};
         r_lds_s <= {r_lds_s[1:0], M68K_LDS_n};
         r_fill  <= r_fill + {1'b0, ~&r_fill};
         r_armed <= r_armed | (&r_fill & w_as);
      end

   // state register
   always_ff @(posedge PI_CLK)
      if (SYS_RESET) r_state <= IDLE;
      else r_state <= w_next;

   // next-state: AS_n negation before a response is a master abort
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = DECODE;
         DECODE:  w_next = (!w_as && w_match) ? LOCAL : RELEASE;
         LOCAL:   if (w_as) w_next = RELEASE;
                  else if (LOC_ACK || w_timeout) w_next = RESPOND;
         RESPOND: if (w_as) w_next = RELEASE;
         RELEASE: if (w_as && w_uds && w_lds) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // local request, capture of the local result and bus responses
   always_ff @(posedge PI_CLK)
      if (SYS_RESET) begin
         M68K_DTACK_n <= 1'b1;
         M68K_BERR_n  <= 1'b1;
         M68K_D_OE    <= 1'b0;
         M68K_D_OUT   <= '0;
         LOC_REQ      <= 1'b0;
         LOC_RW       <= 1'b1;
         LOC_BE       <= '0;
         LOC_ADDR     <= '0;
         LOC_WDATA    <= '0;
         r_err        <= 1'b0;
      end else begin
         LOC_REQ <= (r_state == DECODE) && (w_next == LOCAL);
         if (r_state == DECODE) begin
            LOC_ADDR  <= M68K_A;
            LOC_RW    <= M68K_RW;
            LOC_BE    <= {~w_uds, ~w_lds};
            LOC_WDATA <= M68K_D_IN;
         end
         if (r_state == LOCAL && w_next == RESPOND) begin
            r_err      <= LOC_ACK ? LOC_ERR : 1'b1;
            M68K_D_OUT <= LOC_RDATA;
            if (!LOC_ACK) M68K_BERR_n <= 1'b0;
         end
         if (r_state == RESPOND && w_as) begin
            M68K_DTACK_n <= 1'b1;
            M68K_BERR_n  <= 1'b1;
            M68K_D_OE    <= 1'b0;
         end else if (r_state == RESPOND && w_fall) begin
            if (r_err) M68K_BERR_n <= 1'b0;
            else begin
               M68K_DTACK_n <= 1'b0;
               M68K_D_OE    <= LOC_RW;
            end
         end
      end
endmodule

// File: tb/tb_m68k_bus_target.sv
// tb_m68k_bus_target: drives 68000 bus cycles and a local responder, checks against a decode/response model
`timescale 1ns/100ps
module tb_m68k_bus_target;
   logic        PI_CLK = 1'b0, SYS_RESET = 1'b1, M68K_CLK = 1'b0;
   logic        M68K_AS_n = 1'b1, M68K_UDS_n = 1'b1, M68K_LDS_n = 1'b1, M68K_RW = 1'b1;
   logic [2:0]  M68K_FC = '0;
   logic [22:0] M68K_A = '0;
   logic [15:0] M68K_D_IN = '0;
   logic [15:0] M68K_D_OUT;
   logic        M68K_D_OE, M68K_DTACK_n, M68K_BERR_n, LOC_REQ, LOC_RW;
   logic [22:0] LOC_ADDR;
   logic [1:0]  LOC_BE;
   logic [15:0] LOC_WDATA;
   logic        LOC_ACK = 1'b0, LOC_ERR = 1'b0;
   logic [15:0] LOC_RDATA = '0;
   int errors = 0, checks = 0;
   int o_req, o_rel, o_falls_ack, o_falls_req;
   logic [22:0] o_addr;
   logic [1:0]  o_be;
   logic        o_rw, o_dtack, o_berr, o_both, o_doe, o_doe_resp, o_early, o_timeout;
   logic [15:0] o_wdata, o_dout;

   m68k_bus_target dut (
      .PI_CLK(PI_CLK), .SYS_RESET(SYS_RESET), .M68K_CLK(M68K_CLK),
      .M68K_AS_n(M68K_AS_n), .M68K_UDS_n(M68K_UDS_n), .M68K_LDS_n(M68K_LDS_n),
      .M68K_RW(M68K_RW), .M68K_FC(M68K_FC), .M68K_A(M68K_A), .M68K_D_IN(M68K_D_IN),
      .M68K_D_OUT(M68K_D_OUT), .M68K_D_OE(M68K_D_OE), .M68K_DTACK_n(M68K_DTACK_n),
      .M68K_BERR_n(M68K_BERR_n), .LOC_REQ(LOC_REQ), .LOC_RW(LOC_RW), .LOC_ADDR(LOC_ADDR),
      .LOC_BE(LOC_BE), .LOC_WDATA(LOC_WDATA), .LOC_ACK(LOC_ACK), .LOC_ERR(LOC_ERR),
      .LOC_RDATA(LOC_RDATA)
   );

   always #2.5 PI_CLK = ~PI_CLK;
   always #71 M68K_CLK = ~M68K_CLK;

   // one bus cycle started just after a c7m rising edge; records what the DUT did
   task automatic bus_cycle(input logic [23:0] addr, input logic [2:0] fc, input logic rw,
                            input logic [1:0] ds, input logic [15:0] din, input int ack_dly,
                            input logic err, input logic [15:0] rdata, input int abort_dly,
                            input int max_falls);
      int   cyc, t_req, t_neg, t_resp, falls, f_ack, f_req;
      logic prev, acked;
      cyc = 0; t_req = -1; t_neg = -1; t_resp = -1; falls = 0; f_ack = 0; f_req = 0; acked = 0;
      o_req = 0; o_rel = -1; o_falls_ack = -1; o_falls_req = -1; o_addr = '0; o_be = '0;
      o_rw = 1'b1; o_dtack = 0; o_berr = 0; o_both = 0; o_doe = 0; o_doe_resp = 0;
      o_early = 0; o_timeout = 0; o_wdata = '0; o_dout = '0;
      @(posedge M68K_CLK);
      @(negedge PI_CLK);
      prev = M68K_CLK;
      M68K_A = addr[23:1]; M68K_FC = fc; M68K_RW = rw; M68K_D_IN = din;
      M68K_AS_n = 1'b0; M68K_UDS_n = ~ds[1]; M68K_LDS_n = ~ds[0];
      while (1) begin
         @(negedge PI_CLK);
         cyc++;
         if (prev && !M68K_CLK) falls++;
         prev = M68K_CLK;
         if (LOC_REQ === 1'b1) begin
            o_req++;
            if (t_req < 0) begin
               t_req = cyc; f_req = falls;
               o_addr = LOC_ADDR; o_be = LOC_BE; o_rw = LOC_RW; o_wdata = LOC_WDATA;
            end
         end
         if (M68K_DTACK_n === 1'b0 && M68K_BERR_n === 1'b0) o_both = 1;
         if (M68K_D_OE === 1'b1) o_doe = 1;
         if (t_resp < 0 && (M68K_DTACK_n === 1'b0 || M68K_BERR_n === 1'b0)) begin
            t_resp = cyc;
            o_dtack = ~M68K_DTACK_n; o_berr = ~M68K_BERR_n;
            o_dout = M68K_D_OUT; o_doe_resp = M68K_D_OE;
            o_early = ~acked;
            o_falls_ack = acked ? falls - f_ack : -1;
            o_falls_req = falls - f_req;
         end
         LOC_ACK = 1'b0;
         if (t_req >= 0 && ack_dly >= 0 && !acked && cyc == t_req + ack_dly) begin
            LOC_ACK = 1'b1; LOC_RDATA = rdata; LOC_ERR = err; acked = 1; f_ack = falls;
         end
         if (t_neg < 0 && ((t_resp >= 0 && cyc >= t_resp + 3) ||
             (abort_dly >= 0 && t_req >= 0 && cyc >= t_req + abort_dly) || falls >= max_falls)) begin
            M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1; t_neg = cyc;
         end else if (t_neg >= 0 && o_rel < 0 && M68K_DTACK_n === 1'b1 &&
                      M68K_BERR_n === 1'b1 && M68K_D_OE === 1'b0)
            o_rel = cyc - t_neg;
         if (t_neg >= 0 && cyc >= t_neg + 40 && (acked || ack_dly < 0 || t_req < 0)) break;
         if (cyc > max_falls * 32 + 400) begin o_timeout = 1; break; end
      end
      LOC_ACK = 1'b0; M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1;
   endtask

   task automatic test_reset();
      SYS_RESET = 1'b1;
      repeat (5) @(negedge PI_CLK);
      checks++;
      if ({M68K_DTACK_n, M68K_BERR_n, M68K_D_OE, LOC_REQ, LOC_RW} !== 5'b11001) begin
         errors++; $display("FAIL reset_ctrl got=%b exp=11001", {M68K_DTACK_n, M68K_BERR_n, M68K_D_OE, LOC_REQ, LOC_RW});
      end
      checks++;
      if ({M68K_D_OUT, LOC_ADDR, LOC_BE, LOC_WDATA} !== 57'd0) begin
         errors++; $display("FAIL reset_data got=%h exp=0", {M68K_D_OUT, LOC_ADDR, LOC_BE, LOC_WDATA});
      end
      SYS_RESET = 1'b0;
      repeat (10) @(negedge PI_CLK);
      checks++;
      if ({M68K_DTACK_n, M68K_BERR_n, LOC_REQ} !== 3'b110) begin
         errors++; $display("FAIL reset_idle got=%b exp=110", {M68K_DTACK_n, M68K_BERR_n, LOC_REQ});
      end
   endtask

   task automatic test_read();
      bus_cycle(24'hE90010, 3'd5, 1'b1, 2'b11, 16'h0, 3, 1'b0, 16'hBEEF, -1, 10);
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL read_bound got=%b exp=0", o_timeout); end
      checks++; if (o_req !== 1) begin errors++; $display("FAIL read_req got=%0d exp=1", o_req); end
      checks++; if (o_addr !== 23'h748008) begin errors++; $display("FAIL read_addr got=%h exp=748008", o_addr); end
      checks++; if (o_be !== 2'b11) begin errors++; $display("FAIL read_be got=%b exp=11", o_be); end
      checks++; if ({o_dtack, o_berr, o_early} !== 3'b100) begin errors++; $display("FAIL read_resp got=%b exp=100", {o_dtack, o_berr, o_early}); end
      checks++; if (o_dout !== 16'hBEEF || o_doe_resp !== 1'b1) begin errors++; $display("FAIL read_data got=%h/%b exp=beef/1", o_dout, o_doe_resp); end
      checks++; if (o_falls_ack !== 1) begin errors++; $display("FAIL read_edge got=%0d exp=1", o_falls_ack); end
      checks++; if (!(o_rel >= 0 && o_rel <= 4)) begin errors++; $display("FAIL read_release got=%0d exp<=4", o_rel); end
   endtask

   task automatic test_write();
      bus_cycle(24'hE90003, 3'd1, 1'b0, 2'b01, 16'h00A5, 2, 1'b0, 16'hFFFF, -1, 10);
      checks++; if (o_req !== 1 || o_addr !== 23'h748001) begin errors++; $display("FAIL wr_req got=%0d/%h exp=1/748001", o_req, o_addr); end
      checks++; if ({o_rw, o_be} !== 3'b001) begin errors++; $display("FAIL wr_rw_be got=%b exp=001", {o_rw, o_be}); end
      checks++; if (o_wdata !== 16'h00A5) begin errors++; $display("FAIL wr_data got=%h exp=00a5", o_wdata); end
      checks++; if (o_doe !== 1'b0) begin errors++; $display("FAIL wr_doe got=%b exp=0", o_doe); end
      checks++; if ({o_dtack, o_berr} !== 2'b10) begin errors++; $display("FAIL wr_resp got=%b exp=10", {o_dtack, o_berr}); end
   endtask

   task automatic test_nomatch();
      bus_cycle(24'hBFE001, 3'd5, 1'b1, 2'b01, 16'h0, 2, 1'b0, 16'h1111, -1, 4);
      checks++; if ({o_req != 0, o_dtack, o_berr} !== 3'b000) begin errors++; $display("FAIL nomatch got=%0d/%b%b exp=0/00", o_req, o_dtack, o_berr); end
      bus_cycle(24'hE9FFFE, 3'd7, 1'b1, 2'b11, 16'h0, 2, 1'b0, 16'h1111, -1, 4);
      checks++; if ({o_req != 0, o_dtack, o_berr} !== 3'b000) begin errors++; $display("FAIL fc7 got=%0d/%b%b exp=0/00", o_req, o_dtack, o_berr); end
      bus_cycle(24'hE9FFFE, 3'd6, 1'b1, 2'b10, 16'h0, 0, 1'b0, 16'h5A5A, -1, 10);
      checks++; if (o_req !== 1 || o_be !== 2'b10 || o_addr !== 23'h74FFFF) begin errors++; $display("FAIL after_nomatch_req got=%0d/%b/%h exp=1/10/74ffff", o_req, o_be, o_addr); end
      checks++; if (o_dtack !== 1'b1 || o_dout !== 16'h5A5A) begin errors++; $display("FAIL after_nomatch_resp got=%b/%h exp=1/5a5a", o_dtack, o_dout); end
   endtask

   task automatic test_error();
      bus_cycle(24'hE91234, 3'd2, 1'b1, 2'b11, 16'h0, 5, 1'b1, 16'hCAFE, -1, 10);
      checks++; if ({o_dtack, o_berr, o_doe, o_both} !== 4'b0100) begin errors++; $display("FAIL err_resp got=%b exp=0100", {o_dtack, o_berr, o_doe, o_both}); end
   endtask

   task automatic test_timeout();
`ifdef M68K_TARGET_BERR_TIMEOUT_EN
      bus_cycle(24'hE90020, 3'd5, 1'b1, 2'b11, 16'h0, -1, 1'b0, 16'h0, -1, 80);
      checks++; if ({o_dtack, o_berr} !== 2'b01) begin errors++; $display("FAIL tmo_resp got=%b exp=01", {o_dtack, o_berr}); end
      checks++; if (o_falls_req !== 64) begin errors++; $display("FAIL tmo_edge got=%0d exp=64", o_falls_req); end
`else
      bus_cycle(24'hE90020, 3'd5, 1'b1, 2'b11, 16'h0, -1, 1'b0, 16'h0, -1, 1000);
      checks++; if ({o_dtack, o_berr} !== 2'b00) begin errors++; $display("FAIL notmo_resp got=%b exp=00", {o_dtack, o_berr}); end
`endif
      checks++; if (o_timeout !== 1'b0 || o_req !== 1) begin errors++; $display("FAIL tmo_cycle got=%b/%0d exp=0/1", o_timeout, o_req); end
   endtask

   task automatic test_abort();
      bus_cycle(24'hE90040, 3'd5, 1'b1, 2'b11, 16'h0, 20, 1'b0, 16'h7777, 5, 10);
      checks++; if (o_req !== 1 || {o_dtack, o_berr, o_doe} !== 3'b000) begin errors++; $display("FAIL abort got=%0d/%b exp=1/000", o_req, {o_dtack, o_berr, o_doe}); end
      bus_cycle(24'hE90042, 3'd5, 1'b1, 2'b11, 16'h0, 1, 1'b0, 16'h4321, -1, 10);
      checks++; if (o_dtack !== 1'b1 || o_dout !== 16'h4321) begin errors++; $display("FAIL after_abort got=%b/%h exp=1/4321", o_dtack, o_dout); end
   endtask

   task automatic test_reset_respond();
      int   n;
      logic seen;
      @(posedge M68K_CLK); @(negedge PI_CLK);
      M68K_A = 23'h748100; M68K_FC = 3'd5; M68K_RW = 1'b1;
      M68K_AS_n = 1'b0; M68K_UDS_n = 1'b0; M68K_LDS_n = 1'b0;
      n = 0; while (LOC_REQ !== 1'b1 && n < 100) begin @(negedge PI_CLK); n++; end
      LOC_ACK = 1'b1; LOC_RDATA = 16'h1234; LOC_ERR = 1'b0;
      @(negedge PI_CLK); LOC_ACK = 1'b0;
      n = 0; while (M68K_DTACK_n !== 1'b0 && n < 100) begin @(negedge PI_CLK); n++; end
      checks++; if (M68K_DTACK_n !== 1'b0) begin errors++; $display("FAIL rst_pre_dtack got=%b exp=0", M68K_DTACK_n); end
      SYS_RESET = 1'b1;
      @(negedge PI_CLK);
      checks++; if ({M68K_DTACK_n, M68K_BERR_n, M68K_D_OE} !== 3'b110) begin errors++; $display("FAIL rst_release got=%b exp=110", {M68K_DTACK_n, M68K_BERR_n, M68K_D_OE}); end
      SYS_RESET = 1'b0;
      seen = 0;
      repeat (100) begin @(negedge PI_CLK); if (LOC_REQ === 1'b1 || M68K_DTACK_n === 1'b0) seen = 1; end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_restart got=%b exp=0", seen); end
      M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1;
      repeat (10) @(negedge PI_CLK);
      @(posedge M68K_CLK); @(negedge PI_CLK);
      M68K_AS_n = 1'b0; M68K_UDS_n = 1'b0; M68K_LDS_n = 1'b0;
      n = 0; while (LOC_REQ !== 1'b1 && n < 100) begin @(negedge PI_CLK); n++; end
      checks++; if (LOC_REQ !== 1'b1) begin errors++; $display("FAIL rst_new_req got=%b exp=1", LOC_REQ); end
      LOC_ACK = 1'b1; LOC_RDATA = 16'h5678;
      @(negedge PI_CLK); LOC_ACK = 1'b0;
      n = 0; while (M68K_DTACK_n !== 1'b0 && n < 100) begin @(negedge PI_CLK); n++; end
      checks++; if (M68K_DTACK_n !== 1'b0 || M68K_D_OUT !== 16'h5678) begin errors++; $display("FAIL rst_new_resp got=%b/%h exp=0/5678", M68K_DTACK_n, M68K_D_OUT); end
      M68K_AS_n = 1'b1; M68K_UDS_n = 1'b1; M68K_LDS_n = 1'b1;
      repeat (40) @(negedge PI_CLK);
   endtask

   task automatic test_random();
      for (int i = 0; i < 16; i++) begin
         logic [23:0] addr;
         logic [2:0]  fc;
         logic [1:0]  ds;
         logic [15:0] din, rdata;
         logic        rw, err, match;
         addr  = ($urandom_range(0, 3) != 0) ? {8'hE9, 16'($urandom)} : 24'($urandom);
         fc    = 3'($urandom);
         rw    = 1'($urandom);
         ds    = 2'($urandom_range(1, 3));
         din   = 16'($urandom);
         rdata = 16'($urandom);
         err   = ($urandom_range(0, 3) == 0);
         match = (addr[23:16] == 8'hE9) && (fc != 3'b111);
         bus_cycle(addr, fc, rw, ds, din, $urandom_range(0, 30), err, rdata, -1, match ? 10 : 3);
         checks++; if (o_req !== (match ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_req got=%0d exp=%0d", i, o_req, match); end
         checks++; if ({o_dtack, o_berr, o_both} !== {match & ~err, match & err, 1'b0}) begin errors++; $display("FAIL rnd%0d_resp got=%b exp=%b", i, {o_dtack, o_berr, o_both}, {match & ~err, match & err, 1'b0}); end
         checks++; if (o_doe !== (match & rw & ~err)) begin errors++; $display("FAIL rnd%0d_doe got=%b exp=%b", i, o_doe, match & rw & ~err); end
         if (match) begin
            checks++; if ({o_addr, o_be, o_rw} !== {addr[23:1], ds, rw}) begin errors++; $display("FAIL rnd%0d_fields got=%h exp=%h", i, {o_addr, o_be, o_rw}, {addr[23:1], ds, rw}); end
            checks++; if (!rw && o_wdata !== din) begin errors++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o_wdata, din); end
            checks++; if (rw && !err && o_dout !== rdata) begin errors++; $display("FAIL rnd%0d_rdata got=%h exp=%h", i, o_dout, rdata); end
            checks++; if (o_early !== 1'b0 || !(o_falls_ack == 0 || o_falls_ack == 1)) begin errors++; $display("FAIL rnd%0d_timing got=%b/%0d exp=0/0..1", i, o_early, o_falls_ack); end
            checks++; if (!(o_rel >= 0 && o_rel <= 4)) begin errors++; $display("FAIL rnd%0d_release got=%0d exp<=4", i, o_rel); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_nomatch();
      test_error();
      test_abort();
      test_timeout();
      test_reset_respond();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
